// File: rtl/topk_stream_sorter.sv
// rtl/topk_stream_sorter.sv - streaming top-K selector built from pipelined bitonic sort and merge networks
module topk_stream_sorter #(
  parameter int L      = 2,
  parameter int W      = 16,
  parameter int TYPE_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic                        keep_min,
  input  logic [(1<<L)-1:0]           in_mask,
  input  logic [W*(1<<L)-1:0]         in,
  input  logic [TYPE_W*(1<<L)-1:0]    in_type,
  output logic [W*(1<<L)-1:0]         out,
  output logic [TYPE_W*(1<<L)-1:0]    out_type,
  output logic [L:0]                  out_count,
  output logic                        out_valid
);

  localparam int K     = 1 << L;
  localparam int NSORT = L * (L + 1) / 2;
  localparam int NP    = NSORT + L + 1;
  localparam int LAT   = NSORT + L + 2;
  localparam int BW    = $clog2(LAT);
  localparam int CW    = L + 1;
  localparam logic [BW-1:0] BEND   = BW'(LAT - 2);
  localparam logic [CW:0]   K_WIDE = (CW + 1)'(K);
  localparam logic [CW-1:0] K_CNT  = CW'(K);

  typedef logic [W-1:0]      dvec_t [K];
  typedef logic [TYPE_W-1:0] tvec_t [K];
  typedef enum logic [1:0] {ACCEPT, BUSY, OUT} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   bcnt;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW:0]     cnt_sum;
  logic            last_r, mode_r, eff_mode, acc, fin;
  dvec_t           pd [NP];
  tvec_t           pt [NP];
  dvec_t           nd [NP+1];
  tvec_t           nt [NP+1];
  dvec_t           best_d;
  tvec_t           best_t;

  function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    return m ? (a < b) : (a > b);
  endfunction

  function automatic logic [W-1:0] sentinel(input logic m);
    return {W{m}};
  endfunction

  // One compare-exchange column; merge columns always pull the better value to the lower lane.
  function automatic void cmp_stage(input dvec_t di, input tvec_t ti, input int j, input int k,
                                    input logic m, input logic merge, output dvec_t dq, output tvec_t tq);
    int   l;
    logic sw;
    dq = di;
    tq = ti;
    for (int i = 0; i < K; i++) begin
      l = i ^ j;
      if (l > i) begin
        if (merge || ((i & k) != 0)) sw = better(di[l], di[i], m);
        else                         sw = better(di[i], di[l], m);
        if (sw) begin
          dq[i] = di[l]; dq[l] = di[i];
          tq[i] = ti[l]; tq[l] = ti[i];
        end
      end
    end
  endfunction

  assign eff_mode = (cnt == '0) ? keep_min : mode_r;
  assign acc      = in_valid && in_ready;
  assign fin      = (state == BUSY) && (bcnt == BEND);

  always_comb begin
    cnt_sum = {1'b0, cnt};
    for (int i = 0; i < K; i++) cnt_sum = cnt_sum + {{CW{1'b0}}, in_mask[i]};
    cnt_nx = (cnt_sum > K_WIDE) ? K_CNT : cnt_sum[CW-1:0];
  end

  always_comb begin
    for (int s = 0; s <= NP; s++) begin
      nd[s] = '{default: '0};
      nt[s] = '{default: '0};
    end
    for (int i = 0; i < K; i++) begin
      nd[0][i] = in_mask[i] ? in[W*i +: W] : sentinel(eff_mode);
      nt[0][i] = in_mask[i] ? in_type[TYPE_W*i +: TYPE_W] : '0;
    end
    // Batch sort ends worst-first so the keep stage pairs it against a best-first running list.
    for (int p = 1; p <= L; p++)
      for (int q = p - 1; q >= 0; q--)
        cmp_stage(pd[(p*(p-1))/2 + p - q - 1], pt[(p*(p-1))/2 + p - q - 1], 1 << q, 1 << p,
                  mode_r, 1'b0, nd[(p*(p-1))/2 + p - q], nt[(p*(p-1))/2 + p - q]);
    for (int i = 0; i < K; i++) begin
      if (better(best_d[i], pd[NSORT][i], mode_r)) begin
        nd[NSORT+1][i] = best_d[i];
        nt[NSORT+1][i] = best_t[i];
      end else begin
        nd[NSORT+1][i] = pd[NSORT][i];
        nt[NSORT+1][i] = pt[NSORT][i];
      end
    end
    for (int q = L - 1; q >= 0; q--)
      cmp_stage(pd[NSORT+L-q], pt[NSORT+L-q], 1 << q, K, mode_r, 1'b1,
                nd[NSORT+L-q+1], nt[NSORT+L-q+1]);
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      pd[0] <= nd[0];
      pt[0] <= nt[0];
    end
    for (int s = 1; s < NP; s++) begin
      pd[s] <= nd[s];
      pt[s] <= nt[s];
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_n = BUSY;
      end
      BUSY:    if (fin) state_n = last_r ? OUT : ACCEPT;
      OUT: begin
        out_valid = 1'b1;
        state_n   = ACCEPT;
      end
      default: state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCEPT;
      bcnt      <= '0;
      last_r    <= 1'b0;
      mode_r    <= 1'b1;
      cnt       <= '0;
      best_d    <= '{default: '1};
      best_t    <= '{default: '0};
      out       <= '0;
      out_type  <= '0;
      out_count <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        bcnt   <= '0;
        last_r <= in_last;
        cnt    <= cnt_nx;
        // No real entries yet, so the running best can safely adopt the new mode's sentinel.
        if (cnt == '0) begin
          mode_r <= keep_min;
          for (int i = 0; i < K; i++) best_d[i] <= sentinel(keep_min);
          best_t <= '{default: '0};
        end
      end else if (state == BUSY) begin
        bcnt <= bcnt + 1'b1;
      end
      if (fin) begin
        best_d <= nd[NP];
        best_t <= nt[NP];
        if (last_r) begin
          for (int i = 0; i < K; i++) begin
            out[W*i +: W]                <= nd[NP][i];
            out_type[TYPE_W*i +: TYPE_W] <= nt[NP][i];
          end
          out_count <= cnt;
        end
      end
      if (state == OUT) begin
        cnt <= '0;
        for (int i = 0; i < K; i++) best_d[i] <= sentinel(mode_r);
        best_t <= '{default: '0};
      end
    end
  end

endmodule
